// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
// State encoding is fixed so waveform dumps stay readable across builds.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        StArb  = 1'b0,
        StXfer = 1'b1
    } arb_state_e;

    // Ceil(log2(value)), returns 0 for value <= 1; usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle seen by the write-side arbiter.
// master = arbiter side, slave = producers plus FIFO.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16
) ();
    import fifo_wr_arbiter_pkg::*;

    localparam int unsigned GID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wen;
    logic [FIFO_WIDTH-1:0]         fifo_din;
    logic [GID_W-1:0]              grant_id;
    logic                          busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wen,
        output fifo_din,
        output grant_id,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wen,
        input  fifo_din,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request after 'last', wrapping.
// 'found' is low when no request is set; 'idx' is then 0.
module fifo_wr_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int unsigned       pos;
    logic [IDX_W-1:0]  cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        // Offset 1..NUM_REQ so that 'last' itself is checked last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos  = (int'(last) + k) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, write clock domain.
// Each grant is bounded to BURST_MAX beats; one ARB bubble cycle separates grants.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned BURST_MAX  = 8
) (
    input logic               clk_a,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned      GID_W     = clog2(NUM_REQ);
    localparam int unsigned      CNT_W     = clog2(BURST_MAX + 1);
    localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  owner_q, owner_d;
    logic [GID_W-1:0]  last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [GID_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  owner_valid;
    logic                  xfer;
    logic [NUM_REQ-1:0]    ready;
    logic [FIFO_WIDTH-1:0] din;

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .last  (last_owner_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign owner_valid = bus.req_valid[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        ready        = '0;
        xfer         = 1'b0;

        unique case (state_q)
            StArb: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                ready[owner_q] = ~bus.fifo_full;
                xfer           = owner_valid & ~bus.fifo_full;
                if (!owner_valid) begin
                    // Owner withdrew: release immediately, nothing written this cycle.
                    state_d      = StArb;
                    last_owner_d = owner_q;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d      = StArb;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase

        // The beat in flight when reset hits must not reach the FIFO.
        if (rst) begin
            ready = '0;
            xfer  = 1'b0;
        end
    end

    always_comb begin
        din = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == GID_W'(i)) begin
                din = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q      <= StArb;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.fifo_wen  = xfer;
    assign bus.fifo_din  = din;
    assign bus.grant_id  = owner_q;
    assign bus.busy      = (state_q == StXfer) && !rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO writes go into a scoreboard queue,
// a negedge monitor pops and compares every write the DUT issues.
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t  sb_q[$];

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .FIFO_WIDTH (16),
        .BURST_MAX  (8)
    ) dut (
        .clk_a (clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [15:0] d);
        bus.req_data[i*16 +: 16] = d;
    endtask

    task automatic exp_push(input logic [1:0] id, input logic [15:0] d, input int n);
        wr_t w;
        w.id   = id;
        w.data = d;
        for (int k = 0; k < n; k++) sb_q.push_back(w);
    endtask

    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst || bus.fifo_full) check("no_write_blocked", 32'(bus.fifo_wen), 32'd0);
            if (bus.fifo_wen) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.fifo_din), 32'hFFFF_FFFF);
                end else begin
                    w = sb_q.pop_front();
                    check("write_data", 32'(bus.fifo_din), 32'(w.data));
                    check("write_owner", 32'(bus.grant_id), 32'(w.id));
                end
            end
        end
    endtask

    task automatic stimulus();
        // 1: reset held with every producer requesting
        rst           = 1'b1;
        bus.fifo_full = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 16'hA000 + 16'(i));
        step(); step(); step();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_wen", 32'(bus.fifo_wen), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd0);
        check("post_rst_wen", 32'(bus.fifo_wen), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // 2: fairness under full contention, grants 0,1,2,3,0 of 8 beats each
        for (int g = 0; g < 5; g++) exp_push(2'(g % 4), 16'hA000 + 16'(g % 4), 8);
        for (int j = 1; j <= 45; j++) begin
            step();
            if (j % 9 == 0) begin
                check("fair_gap_busy", 32'(bus.busy), 32'd0);
                check("fair_gap_wen", 32'(bus.fifo_wen), 32'd0);
            end
            if (j % 9 == 1) check("fair_grant", 32'(bus.grant_id), 32'((j / 9) % 4));
        end
        bus.req_valid = 4'b0000;
        step(); step();
        check("fair_drain", 32'(sb_q.size()), 32'd0);

        // 3: req 2 alone for 3 beats, then drops; re-request wins after one ARB cycle
        set_data(2, 16'hB000);
        exp_push(2'd2, 16'hB000, 1);
        bus.req_valid = 4'b0100;
        step();
        check("t3_grant", 32'(bus.grant_id), 32'd2);
        for (int k = 1; k < 3; k++) begin
            step();
            set_data(2, 16'hB000 + 16'(k));
            exp_push(2'd2, 16'hB000 + 16'(k), 1);
        end
        step();
        bus.req_valid = 4'b0000;
        #1;
        check("t3_release_wen", 32'(bus.fifo_wen), 32'd0);
        step();
        check("t3_busy_low", 32'(bus.busy), 32'd0);
        set_data(2, 16'hB003);
        exp_push(2'd2, 16'hB003, 1);
        bus.req_valid = 4'b0100;
        step();
        check("t3_regrant", 32'(bus.grant_id), 32'd2);
        check("t3_regrant_busy", 32'(bus.busy), 32'd1);
        step();
        bus.req_valid = 4'b0000;
        step();
        check("t3_drain", 32'(sb_q.size()), 32'd0);

        // 4: full stall after beat 4 of req 1, then 4 more beats and rotate to req 2
        set_data(1, 16'hC100);
        set_data(2, 16'hC200);
        bus.req_valid = 4'b0110;
        exp_push(2'd1, 16'hC100, 4);
        step();
        check("t4_grant", 32'(bus.grant_id), 32'd1);
        for (int k = 0; k < 4; k++) step();
        bus.fifo_full = 1'b1;
        #1;
        check("t4_stall_ready", 32'(bus.req_ready), 32'd0);
        check("t4_stall_wen", 32'(bus.fifo_wen), 32'd0);
        for (int k = 0; k < 5; k++) step();
        check("t4_stall_busy", 32'(bus.busy), 32'd1);
        check("t4_stall_owner", 32'(bus.grant_id), 32'd1);
        check("t4_stall_pending", 32'(sb_q.size()), 32'd0);
        bus.fifo_full = 1'b0;
        exp_push(2'd1, 16'hC100, 4);
        exp_push(2'd2, 16'hC200, 8);
        #1;
        check("t4_resume_ready", 32'(bus.req_ready), 32'b0010);
        for (int k = 0; k < 4; k++) step();
        check("t4_rotate_gap", 32'(bus.busy), 32'd0);
        step();
        check("t4_rotate_grant", 32'(bus.grant_id), 32'd2);
        for (int k = 0; k < 8; k++) step();
        bus.req_valid = 4'b0000;
        step();
        check("t4_drain", 32'(sb_q.size()), 32'd0);

        // 5: last owner 3, only req 1 requests -> pointer wraps past absent req 0
        set_data(3, 16'hD300);
        exp_push(2'd3, 16'hD300, 1);
        bus.req_valid = 4'b1000;
        step();
        check("t5_grant3", 32'(bus.grant_id), 32'd3);
        step();
        bus.req_valid = 4'b0000;
        step();
        set_data(1, 16'hD100);
        exp_push(2'd1, 16'hD100, 1);
        bus.req_valid = 4'b0010;
        step();
        check("t5_wrap_grant", 32'(bus.grant_id), 32'd1);
        step();
        bus.req_valid = 4'b0000;
        step();
        check("t5_drain", 32'(sb_q.size()), 32'd0);

        // 6: reset during beat 5 of req 0; restart grants req 0 first
        set_data(0, 16'hE000);
        exp_push(2'd0, 16'hE000, 1);
        bus.req_valid = 4'b0001;
        step();
        check("t6_grant", 32'(bus.grant_id), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            set_data(0, 16'hE000 + 16'(k));
            if (k < 4) exp_push(2'd0, 16'hE000 + 16'(k), 1);
        end
        rst = 1'b1;
        #1;
        check("t6_rst_wen", 32'(bus.fifo_wen), 32'd0);
        check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;
        set_data(0, 16'hE100);
        bus.req_valid = 4'b1111;
        exp_push(2'd0, 16'hE100, 8);
        #1;
        check("t6_post_busy", 32'(bus.busy), 32'd0);
        step();
        check("t6_restart_grant", 32'(bus.grant_id), 32'd0);
        for (int k = 0; k < 8; k++) step();
        bus.req_valid = 4'b0000;
        step(); step();
        check("final_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        fork
            monitor();
            stimulus();
        join
    end

endmodule
